alu_driver: RTL

Sequencing front end for the team's 8-bit combinational add/sub unit. It accepts operation requests (x, y, judge) over a valid/ready handshake and buffers them in a small FIFO. It drives each request onto the ALU's x/y/judge inputs, holds them for a programmable settle time, then captures result/overflow and presents them downstream over a second valid/ready handshake. It sits between a request source (testbench, nvboard switch logic or a CPU datapath stub) and the combinational ALU instance.

---
 rtl/alu_driver_if.sv | 34 +++
 rtl/alu_driver.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_driver_if.sv
// +--------------------------------------------------------------------+
// | alu_driver_if                                                      |
// | Request and response valid/ready channels of the ALU sequencer.    |
// | master: request source / result sink.  slave: alu_driver.          |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

interface alu_driver_if;
  // request channel
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_x;
  logic [7:0] in_y;
  logic       in_judge;
  // response channel
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic       out_overflow;
  logic       out_zero;

  modport master (
    output in_valid, in_x, in_y, in_judge, out_ready,
    input  in_ready, out_valid, out_result, out_overflow, out_zero
  );

  modport slave (
    input  in_valid, in_x, in_y, in_judge, out_ready,
    output in_ready, out_valid, out_result, out_overflow, out_zero
  );
endinterface

`default_nettype wire

// File: rtl/alu_driver.sv
// +--------------------------------------------------------------------+
// | alu_driver                                                         |
// | Sequencing front end for an 8-bit combinational add/sub ALU.       |
// | Requests are queued in a DEPTH-entry FIFO, driven onto the ALU for |
// | SETTLE cycles, then result/overflow are captured and offered on a  |
// | valid/ready output channel.                                        |
// | Optional build macro: ALU_CHECK_EN adds a reference model with the |
// | mismatch_o / err_count_o ports.                                    |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

module alu_driver #(
  parameter int DEPTH  = 4,   // power of two, 2..16
  parameter int SETTLE = 1    // 1..15
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  alu_driver_if.slave     bus,
  output logic [7:0]      alu_x_o,
  output logic [7:0]      alu_y_o,
  output logic            alu_judge_o,
  input  wire logic [7:0] alu_result_i,
  input  wire logic       alu_overflow_i,
`ifdef ALU_CHECK_EN
  output logic            mismatch_o,
  output logic [7:0]      err_count_o,
`endif
  output logic            busy_o
);

  localparam int              AW        = $clog2(DEPTH);
  localparam logic [AW:0]     c_ptr_one = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]     c_ptr_zero = '0;
  localparam logic [3:0]      c_settle  = 4'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  // ------------------------------------------------------------------
  // Request FIFO: pointers carry one extra bit to tell full from empty
  // ------------------------------------------------------------------
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [16:0]  mem_q [DEPTH];

  logic         w_empty;
  logic         w_full;
  logic         w_push;
  logic         w_pop;
  logic [16:0]  w_head;

  // FSM / datapath registers
  state_t       state_q;
  logic [3:0]   cnt_q;
  logic [7:0]   drv_x_q;
  logic [7:0]   drv_y_q;
  logic         drv_judge_q;
  logic         out_valid_q;
  logic [7:0]   out_result_q;
  logic         out_overflow_q;

  logic         w_hs_out;
  logic         w_capture;

  assign w_empty = (wr_ptr_q == rd_ptr_q);
  assign w_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // in_ready is held low while reset is asserted so nothing is accepted
  assign bus.in_ready = rst_n && !w_full;
  assign w_push       = bus.in_valid && bus.in_ready;

  assign w_hs_out  = out_valid_q && bus.out_ready;
  assign w_capture = (state_q == S_DRIVE) && (cnt_q == 4'd1);

  // A pop happens when the FSM is free to take a new operation: idle, or
  // a result is being handed off in HOLD. No same-cycle bypass of a push.
  assign w_pop = !w_empty &&
                 ((state_q == S_IDLE) || ((state_q == S_HOLD) && w_hs_out));

  assign w_head = mem_q[rd_ptr_q[AW-1:0]];

  // Next-state pointer arithmetic; simultaneous push and pop both advance
  always_comb begin
    wr_ptr_d = wr_ptr_q + (w_push ? c_ptr_one : c_ptr_zero);
    rd_ptr_d = rd_ptr_q + (w_pop  ? c_ptr_one : c_ptr_zero);
  end

  // Pointer registers; reset empties the FIFO and drops queued requests
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // FIFO storage write; contents need no reset since pointers gate reads
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {bus.in_x, bus.in_y, bus.in_judge};
    end
  end

  // Sequencer FSM: IDLE -> DRIVE (settle) -> HOLD (await handoff)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= 4'd0;
      drv_x_q        <= 8'h00;
      drv_y_q        <= 8'h00;
      drv_judge_q    <= 1'b0;
      out_valid_q    <= 1'b0;
      out_result_q   <= 8'h00;
      out_overflow_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_pop) begin
            drv_x_q     <= w_head[16:9];
            drv_y_q     <= w_head[8:1];
            drv_judge_q <= w_head[0];
            cnt_q       <= c_settle;
            state_q     <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            out_result_q   <= alu_result_i;
            out_overflow_q <= alu_overflow_i;
            out_valid_q    <= 1'b1;
            state_q        <= S_HOLD;
          end
        end
        S_HOLD: begin
          // out_* and the drive registers stay frozen until handoff
          if (w_hs_out) begin
            out_valid_q <= 1'b0;
            if (w_pop) begin
              drv_x_q     <= w_head[16:9];
              drv_y_q     <= w_head[8:1];
              drv_judge_q <= w_head[0];
              cnt_q       <= c_settle;
              state_q     <= S_DRIVE;
            end else begin
              state_q     <= S_IDLE;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // ALU operands come straight from the drive registers, which only change
  // on a pop, so they hold their last value outside DRIVE
  assign alu_x_o     = drv_x_q;
  assign alu_y_o     = drv_y_q;
  assign alu_judge_o = drv_judge_q;

  assign bus.out_valid    = out_valid_q;
  assign bus.out_result   = out_result_q;
  assign bus.out_overflow = out_overflow_q;
  assign bus.out_zero     = (out_result_q == 8'h00);

  assign busy_o = (state_q != S_IDLE) || !w_empty;

`ifdef ALU_CHECK_EN
  // ------------------------------------------------------------------
  // Reference model of the add/sub unit, evaluated on the drive registers
  // ------------------------------------------------------------------
  logic [7:0] w_ref_y;
  logic [7:0] w_ref_sum;
  logic       w_ref_ovf;
  logic       w_mis;
  logic       mismatch_q;
  logic [7:0] err_count_q;

  // Subtract is x + ~y + 1. With the effective (possibly inverted) y, both
  // the add and sub overflow rules reduce to: same-sign operands, and the
  // result sign differs from x.
  always_comb begin
    w_ref_y   = drv_judge_q ? ~drv_y_q : drv_y_q;
    w_ref_sum = drv_x_q + w_ref_y + {7'd0, drv_judge_q};
    w_ref_ovf = (drv_x_q[7] == w_ref_y[7]) && (w_ref_sum[7] != drv_x_q[7]);
    w_mis     = (alu_result_i != w_ref_sum) || (alu_overflow_i != w_ref_ovf);
  end

  // Mismatch flag tracks the presented result; error counter saturates
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mismatch_q  <= 1'b0;
      err_count_q <= 8'h00;
    end else if (w_capture) begin
      mismatch_q <= w_mis;
      if (w_mis && (err_count_q != 8'hFF)) begin
        err_count_q <= err_count_q + 8'd1;
      end
    end else if (w_hs_out) begin
      mismatch_q <= 1'b0;
    end
  end

  assign mismatch_o  = mismatch_q;
  assign err_count_o = err_count_q;
`endif

endmodule

`default_nettype wire
